// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the shift sequencer and its single-bit stage.
// Provides the sequencer state enum, datapath widths and shift-mode encodings.
package cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SHAMT_W = 3;

  // Shift-mode encodings for the LR and LA controls.
  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;
  localparam logic SHIFT_ARITH = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shifter.sv
// Single-bit shift stage (purely combinational).
// Ports:
//   A  - operand
//   LA - 1 = arithmetic right shift (ignored for left shifts)
//   LR - 0 = left, 1 = right
//   Y  - operand shifted by one position
//   C  - the bit shifted out
module shifter
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic              LA,
  input  logic              LR,
  output logic [DATA_W-1:0] Y,
  output logic              C
);

  always_comb begin
    Y = A;
    C = 1'b0;
    if (LR == SHIFT_LEFT) begin
      Y = {A[DATA_W-2:0], 1'b0};
      C = A[DATA_W-1];
    end else begin
      // Arithmetic mode replicates the sign bit into the vacated MSB.
      Y = {(LA == SHIFT_ARITH) ? A[DATA_W-1] : 1'b0, A[DATA_W-1:1]};
      C = A[0];
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: loops an operand through the single-bit shifter once
// per clock, N times, then pulses done with the final value, carry and zero flag.
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   start            - request a new shift (sampled only when idle)
//   A, N, LA, LR     - operand, shift amount, arithmetic flag, direction
//   Y, C, Z          - registered result, registered carry, combinational zero flag
//   busy, done       - not-idle indicator, single-cycle completion pulse
module shift_sequencer
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DATA_W-1:0]  A,
  input  logic [SHAMT_W-1:0] N,
  input  logic               LA,
  input  logic               LR,
  output logic [DATA_W-1:0]  Y,
  output logic               C,
  output logic               Z,
  output logic               busy,
  output logic               done
);

  state_t               state_q;
  logic [DATA_W-1:0]    y_q;
  logic                 c_q;
  logic                 done_q;
  logic [SHAMT_W-1:0]   count_q;
  logic                 la_q;
  logic                 lr_q;

  logic [DATA_W-1:0]    stage_y;
  logic                 stage_c;

  // The shifter is the only combinational logic inside the SHIFT feedback loop.
  shifter u_shifter (
    .A  (y_q),
    .LA (la_q),
    .LR (lr_q),
    .Y  (stage_y),
    .C  (stage_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= '0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      la_q    <= 1'b0;
      lr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            y_q     <= A;
            c_q     <= 1'b0;
            count_q <= N;
            la_q    <= LA;
            lr_q    <= LR;
            if (N != '0) begin
              state_q <= SHIFT;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          y_q     <= stage_y;
          c_q     <= stage_c;
          count_q <= count_q - 1'b1;
          if (count_q == SHAMT_W'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Y    = y_q;
  assign C    = c_q;
  assign Z    = (y_q == '0);
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule
